// File: rtl/wire_cmd_responder.sv
// wire_cmd_responder: a host writes a command word and two operands, and this block computes the result.
// An 8-bit sequence number in the command word hands off the request.
// When the result is ready it is published and the sequence number is acknowledged.
// ADD, SUB and the reserved opcode take one execute cycle.
// MUL is a 32-cycle shift-add.
// The results, the acknowledged sequence number and the error flag change together on the DONE edge.
module wire_cmd_responder (
    input  logic        ti_clk,
    input  logic        reset,
    input  logic [31:0] cmd_word,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [31:0] result_lo,
    output logic [31:0] result_hi,
    output logic [31:0] status
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_RSV = 2'd3;

    state_t      state;
    logic [7:0]  ack_seq;
    logic [7:0]  lat_seq;
    logic [1:0]  lat_op;
    logic        busy;
    logic        error;
    logic [4:0]  cycle_cnt;
    logic [63:0] acc;
    logic [63:0] mcand;
    logic [31:0] mplier;

    logic [32:0] add_sum;
    logic [31:0] sub_diff;
    logic        sub_borrow;
    logic [63:0] mul_next;
    logic        unused_cmd_bits;

    // The upper command bits carry no meaning and are deliberately left unused.
    assign unused_cmd_bits = ^cmd_word[31:10];

    // During execution, operand A lives in the low half of mcand and operand B lives in mplier.
    always_comb begin
        add_sum    = {1'b0, mcand[31:0]} + {1'b0, mplier};
        sub_diff   = mcand[31:0] - mplier;
        sub_borrow = (mcand[31:0] < mplier);
        mul_next   = mplier[0] ? (acc + mcand) : acc;
    end

    // The status word is a fixed repacking of registered flags only.
    assign status = {22'd0, error, busy, ack_seq};

    // Command FSM: detect a new seq, execute, then publish everything on one edge.
    always_ff @(posedge ti_clk) begin
        if (reset) begin
            state     <= IDLE;
            result_lo <= 32'd0;
            result_hi <= 32'd0;
            busy      <= 1'b0;
            error     <= 1'b0;
            cycle_cnt <= 5'd0;
            ack_seq   <= cmd_word[7:0];
            lat_seq   <= 8'd0;
            lat_op    <= OP_ADD;
            acc       <= 64'd0;
            mcand     <= 64'd0;
            mplier    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_word[7:0] != ack_seq) begin
                        mcand     <= {32'd0, op_a};
                        mplier    <= op_b;
                        lat_op    <= cmd_word[9:8];
                        lat_seq   <= cmd_word[7:0];
                        acc       <= 64'd0;
                        cycle_cnt <= 5'd0;
                        busy      <= 1'b1;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    case (lat_op)
                        OP_ADD: begin
                            acc   <= {31'd0, add_sum};
                            state <= DONE;
                        end
                        OP_SUB: begin
                            acc   <= {(sub_borrow ? 32'hFFFF_FFFF : 32'd0), sub_diff};
                            state <= DONE;
                        end
                        OP_MUL: begin
                            acc       <= mul_next;
                            mcand     <= mcand << 1;
                            mplier    <= mplier >> 1;
                            cycle_cnt <= cycle_cnt + 5'd1;
                            if (cycle_cnt == 5'd31) begin
                                state <= DONE;
                            end
                        end
                        default: begin
                            state <= DONE;
                        end
                    endcase
                end
                DONE: begin
                    if (lat_op == OP_RSV) begin
                        error <= 1'b1;
                    end else begin
                        result_lo <= acc[31:0];
                        result_hi <= acc[63:32];
                        error     <= 1'b0;
                    end
                    ack_seq <= lat_seq;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wire_cmd_responder.sv
// Testbench for wire_cmd_responder.
// A table of directed commands is checked for latency, busy and atomic publishing.
// Hand-written sequences cover seq rewrites during MUL, the reserved opcode and reset mid-EXEC.
module tb_wire_cmd_responder;

    logic        ti_clk;
    logic        reset;
    logic [31:0] cmd_word;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic [31:0] status;

    int compared;
    int mismatched;

    typedef struct {
        logic [31:0] cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_status;
        int          latency;
    } vec_t;

    vec_t vecs[7];

    wire_cmd_responder dut (
        .ti_clk    (ti_clk),
        .reset     (reset),
        .cmd_word  (cmd_word),
        .op_a      (op_a),
        .op_b      (op_b),
        .result_lo (result_lo),
        .result_hi (result_hi),
        .status    (status)
    );

    // Free-running 10 ns host-interface clock.
    initial begin
        ti_clk = 1'b0;
        forever #5 ti_clk = ~ti_clk;
    end

    task automatic step();
        @(posedge ti_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] c, input logic [31:0] a, input logic [31:0] b);
        cmd_word = c;
        op_a     = a;
        op_b     = b;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Directed test sequence: reset, table, hand-written corner cases.
    initial begin
        logic [31:0] prev_lo;
        logic [31:0] prev_hi;
        logic [31:0] prev_st;
        int          saw_four;

        compared   = 0;
        mismatched = 0;
        saw_four   = 0;

        vecs[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 3};
        vecs[1] = '{32'h0000_0102, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0002, 3};
        vecs[2] = '{32'h0000_0110, 32'h0000_000A, 32'h0000_0003, 32'h0000_0007, 32'h0000_0000, 32'h0000_0010, 3};
        vecs[3] = '{32'h0000_0211, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 32'h0000_0001, 32'h0000_0011, 34};
        vecs[4] = '{32'hFFFF_FCFF, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0001, 32'h0000_00FF, 3};
        vecs[5] = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0000, 3};
        vecs[6] = '{32'h0000_0201, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 34};

        // Reset: ack_seq tracks cmd_word, and the results and flags clear.
        reset = 1'b1;
        applyStimulus(32'h0000_0055, 32'd0, 32'd0);
        step();
        step();
        checkOutput("reset_lo", result_lo, 32'd0);
        checkOutput("reset_hi", result_hi, 32'd0);
        checkOutput("reset_status_track", status, 32'h0000_0055);
        applyStimulus(32'h0000_0000, 32'd0, 32'd0);
        step();
        checkOutput("reset_status_seq0", status, 32'h0000_0000);
        reset = 1'b0;
        repeat (4) step();
        checkOutput("post_reset_idle", status, 32'h0000_0000);

        prev_lo = 32'd0;
        prev_hi = 32'd0;
        prev_st = 32'd0;

        // Table-driven commands with latency and atomicity checks.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].cmd, vecs[i].a, vecs[i].b);
            step();
            checkOutput($sformatf("v%0d_busy_edge1", i), status, prev_st | 32'h100);
            repeat (vecs[i].latency - 2) step();
            checkOutput($sformatf("v%0d_hold_lo", i), result_lo, prev_lo);
            checkOutput($sformatf("v%0d_hold_status", i), status, prev_st | 32'h100);
            step();
            checkOutput($sformatf("v%0d_lo", i), result_lo, vecs[i].exp_lo);
            checkOutput($sformatf("v%0d_hi", i), result_hi, vecs[i].exp_hi);
            checkOutput($sformatf("v%0d_status", i), status, vecs[i].exp_status);
            step();
            checkOutput($sformatf("v%0d_idle_status", i), status, vecs[i].exp_status);
            prev_lo = vecs[i].exp_lo;
            prev_hi = vecs[i].exp_hi;
            prev_st = vecs[i].exp_status;
        end

        // MUL 0xFFFFFFFF^2; seq rewritten to 0x04 then 0x05 during EXEC.
        applyStimulus(32'h0000_0203, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int e = 1; e <= 33; e++) begin
            step();
            if (status[7:0] == 8'h04) saw_four = 1;
            if (e == 1 || e == 33) begin
                checkOutput($sformatf("mul_busy_e%0d", e), status, 32'h0000_0101);
            end else if (status !== 32'h0000_0101) begin
                checkOutput($sformatf("mul_busy_e%0d", e), status, 32'h0000_0101);
            end
            if (e == 5)  applyStimulus(32'h0000_0004, 32'd1, 32'd1);
            if (e == 15) applyStimulus(32'h0000_0005, 32'd1, 32'd1);
        end
        step();
        checkOutput("mul_lo", result_lo, 32'h0000_0001);
        checkOutput("mul_hi", result_hi, 32'hFFFF_FFFE);
        checkOutput("mul_status", status, 32'h0000_0003);
        step();
        if (status[7:0] == 8'h04) saw_four = 1;
        checkOutput("latest_seq_busy", status, 32'h0000_0103);
        step();
        step();
        checkOutput("latest_seq_lo", result_lo, 32'h0000_0002);
        checkOutput("latest_seq_hi", result_hi, 32'h0000_0000);
        checkOutput("latest_seq_status", status, 32'h0000_0005);
        repeat (3) step();
        checkOutput("latest_seq_once", status, 32'h0000_0005);
        checkOutput("seq4_never_acked", 32'(saw_four), 32'd0);

        // Reserved opcode keeps the previous result and flags an error.
        applyStimulus(32'h0000_0007, 32'h0000_1000, 32'h0000_0234);
        repeat (3) step();
        checkOutput("pre_rsv_lo", result_lo, 32'h0000_1234);
        checkOutput("pre_rsv_status", status, 32'h0000_0007);
        applyStimulus(32'h0000_0306, 32'd9, 32'd9);
        step();
        checkOutput("rsv_busy", status, 32'h0000_0107);
        step();
        step();
        checkOutput("rsv_lo_held", result_lo, 32'h0000_1234);
        checkOutput("rsv_hi_held", result_hi, 32'h0000_0000);
        checkOutput("rsv_status", status, 32'h0000_0206);

        // Reset at MUL cycle 10 aborts; ack_seq follows cmd_word during reset.
        applyStimulus(32'h0000_0208, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step();
        checkOutput("abort_mul_busy", status, 32'h0000_0306);
        repeat (10) step();
        reset = 1'b1;
        step();
        checkOutput("abort_lo", result_lo, 32'd0);
        checkOutput("abort_hi", result_hi, 32'd0);
        checkOutput("abort_status", status, 32'h0000_0008);
        applyStimulus(32'h0000_0209, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step();
        checkOutput("abort_status_track", status, 32'h0000_0009);
        reset = 1'b0;
        repeat (40) step();
        checkOutput("abort_no_exec_lo", result_lo, 32'd0);
        checkOutput("abort_no_exec_hi", result_hi, 32'd0);
        checkOutput("abort_no_exec_status", status, 32'h0000_0009);

        // After the abort, a new seq still runs normally.
        applyStimulus(32'h0000_000A, 32'd2, 32'd3);
        repeat (3) step();
        checkOutput("post_abort_lo", result_lo, 32'h0000_0005);
        checkOutput("post_abort_status", status, 32'h0000_000A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
